// File: rtl/bip_mem_if.sv
// Program/data memory bus between the BIP sequencer and its memories.
// Master is the sequencer; slave is the memory side.
interface bip_mem_if #(
  parameter int NB_BITS = 16,
  parameter int NB_ADDR = 11
);
  logic [NB_BITS-1:0] i_instr;
  logic [NB_ADDR-1:0] o_pc_addr;
  logic [NB_ADDR-1:0] o_data_addr;
  logic               o_rd_ram;
  logic               o_wr_ram;

  modport master (
    input  i_instr,
    output o_pc_addr, o_data_addr,
    output o_rd_ram, o_wr_ram
  );

  modport slave (
    output i_instr,
    input  o_pc_addr, o_data_addr,
    input  o_rd_ram, o_wr_ram
  );
endinterface

// File: rtl/bip_control.sv
// BIP accumulator processor sequencer: PC, fetch/decode/exec FSM,
// datapath strobes, halt/busy status and execution cycle counter.
module bip_control #(
  parameter int NB_BITS   = 16,
  parameter int NB_ADDR   = 11,
  parameter int NB_OPCODE = NB_BITS - NB_ADDR,
  parameter int NB_CNT    = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  bip_mem_if.master         mem,
  output logic [1:0]        o_sel_a,
  output logic              o_sel_b,
  output logic              o_wr_acc,
  output logic              o_op_code,
  output logic              o_busy,
  output logic              o_halt,
  output logic [NB_CNT-1:0] o_cycle_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
  localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
  localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
  localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
  localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
  localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
  localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
  localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);

  logic [2:0]           state;
  logic [NB_ADDR-1:0]   pc;
  logic [NB_BITS-1:0]   ir;
  logic [NB_CNT-1:0]    cnt;
  logic [NB_OPCODE-1:0] ir_op;
  logic [NB_OPCODE-1:0] in_op;
  logic                 is_dec;
  logic                 is_exe;

  assign ir_op  = ir[NB_BITS-1:NB_ADDR];
  assign in_op  = mem.i_instr[NB_BITS-1:NB_ADDR];
  assign is_dec = (state == S_DECODE);
  assign is_exe = (state == S_EXEC);

  assign o_busy        = (state == S_FETCH) || is_dec || is_exe;
  assign o_halt        = (state == S_HALT);
  assign o_cycle_count = cnt;
  assign mem.o_pc_addr = pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      if (o_busy && cnt != '1)
        cnt <= cnt + 1'b1;
      case (state)
        S_IDLE:   if (i_start) state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          ir    <= mem.i_instr;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (ir_op == OP_HLT) begin
            state <= S_HALT;
          end else begin
            pc    <= pc + 1'b1;
            state <= S_FETCH;
          end
        end
        S_HALT:   state <= S_HALT;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_sel_a         = 2'b00;
    o_sel_b         = 1'b0;
    o_wr_acc        = 1'b0;
    o_op_code       = 1'b0;
    mem.o_rd_ram    = 1'b0;
    mem.o_wr_ram    = 1'b0;
    mem.o_data_addr = ir[NB_ADDR-1:0];
    unique case (1'b1)
      is_dec: begin
        mem.o_data_addr = mem.i_instr[NB_ADDR-1:0];
        mem.o_rd_ram    = (in_op == OP_LD) ||
                          (in_op == OP_ADD) ||
                          (in_op == OP_SUB);
      end
      is_exe: begin
        case (ir_op)
          OP_STO:  mem.o_wr_ram = 1'b1;
          OP_LD:   o_wr_acc = 1'b1;
          OP_LDI: begin
            o_wr_acc = 1'b1;
            o_sel_a  = 2'b01;
          end
          OP_ADD: begin
            o_wr_acc  = 1'b1;
            o_sel_a   = 2'b10;
            o_op_code = 1'b1;
          end
          OP_ADDI: begin
            o_wr_acc  = 1'b1;
            o_sel_a   = 2'b10;
            o_sel_b   = 1'b1;
            o_op_code = 1'b1;
          end
          OP_SUB: begin
            o_wr_acc = 1'b1;
            o_sel_a  = 2'b10;
          end
          OP_SUBI: begin
            o_wr_acc = 1'b1;
            o_sel_a  = 2'b10;
            o_sel_b  = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bip_control.sv
// Bench for bip_control: memories, accumulator datapath and an
// instruction-level reference model compared every cycle.
module tb_bip_control;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start_w;
  logic [1:0]  sel_a;
  logic        sel_b, wr_acc, op, busy, halt;
  logic [31:0] cnt;
  logic [1:0]  w_sel_a;
  logic        w_sel_b, w_wr_acc, w_op, w_busy, w_halt;
  logic [31:0] w_cnt;

  bip_mem_if #(.NB_BITS(16), .NB_ADDR(11)) mbus ();
  bip_mem_if #(.NB_BITS(9),  .NB_ADDR(4))  wbus ();

  bip_control dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .mem(mbus),
    .o_sel_a(sel_a), .o_sel_b(sel_b), .o_wr_acc(wr_acc),
    .o_op_code(op), .o_busy(busy), .o_halt(halt),
    .o_cycle_count(cnt)
  );

  bip_control #(.NB_BITS(9), .NB_ADDR(4)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_start(start_w), .mem(wbus),
    .o_sel_a(w_sel_a), .o_sel_b(w_sel_b), .o_wr_acc(w_wr_acc),
    .o_op_code(w_op), .o_busy(w_busy), .o_halt(w_halt),
    .o_cycle_count(w_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // memories and accumulator datapath
  logic [15:0] prog [2048];
  logic [15:0] dmem [2048];
  logic [15:0] rdata;
  logic [15:0] acc;

  function automatic logic [15:0] sx(logic [10:0] v);
    return {{5{v[10]}}, v};
  endfunction

  function automatic logic [15:0] nacc();
    logic [15:0] b;
    b = sel_b ? sx(mbus.o_data_addr) : rdata;
    case (sel_a)
      2'b00:   return rdata;
      2'b01:   return sx(mbus.o_data_addr);
      2'b10:   return op ? acc + b : acc - b;
      default: return acc;
    endcase
  endfunction

  always @(posedge clk) begin
    mbus.i_instr <= prog[mbus.o_pc_addr];
    wbus.i_instr <= {5'b01000, wbus.o_pc_addr};
    rdata <= dmem[mbus.o_data_addr];
    if (rst) begin
      acc     <= 16'd0;
      dmem[4] <= 16'd10;
      dmem[5] <= 16'd3;
    end else begin
      if (mbus.o_wr_ram) dmem[mbus.o_data_addr] <= acc;
      if (wr_acc) acc <= nacc();
    end
  end

  // reference model: cycle k after first FETCH is phase k%3 of instr k/3
  bit          m_act, m_halt;
  int          m_k, m_cnt;
  logic [10:0] m_opnd;
  int          mpc, ph;
  logic [4:0]  mop;

  always_comb begin
    mpc = (m_k / 3) % 2048;
    ph  = m_k % 3;
    mop = prog[mpc][15:11];
  end

  always @(posedge clk) begin
    if (rst) begin
      m_act <= 0; m_halt <= 0; m_k <= 0; m_cnt <= 0; m_opnd <= '0;
    end else if (!m_act) begin
      if (start) m_act <= 1;
    end else if (!m_halt) begin
      m_cnt <= m_cnt + 1;
      if (ph == 1) m_opnd <= prog[mpc][10:0];
      if (ph == 2 && mop == 5'd0) m_halt <= 1;
      else m_k <= m_k + 1;
    end
  end

  function automatic logic [5:0] tbl(logic [4:0] o);
    // {wr_ram, wr_acc, sel_a, sel_b, add}
    case (o)
      5'd1:    return 6'b10_00_0_0;
      5'd2:    return 6'b01_00_0_0;
      5'd3:    return 6'b01_01_0_0;
      5'd4:    return 6'b01_10_0_1;
      5'd5:    return 6'b01_10_1_1;
      5'd6:    return 6'b01_10_0_0;
      5'd7:    return 6'b01_10_1_0;
      default: return 6'b00_00_0_0;
    endcase
  endfunction

  logic [10:0] rdq [$];

  always @(negedge clk) begin
    if (chk_en) begin
      bit   e_busy, e_dec, e_exe, e_rd;
      logic [5:0]  e_ctl;
      logic [10:0] e_da;
      e_busy = m_act && !m_halt;
      e_dec  = e_busy && ph == 1;
      e_exe  = e_busy && ph == 2;
      e_ctl  = e_exe ? tbl(mop) : 6'd0;
      e_rd   = e_dec && (mop == 5'd2 || mop == 5'd4 || mop == 5'd6);
      e_da   = e_dec ? prog[mpc][10:0] : m_opnd;
      chk("ctl", {mbus.o_wr_ram, wr_acc, sel_a, sel_b, op, mbus.o_rd_ram},
          {e_ctl, e_rd});
      chk("pc", 64'(mbus.o_pc_addr), 64'(mpc));
      chk("daddr", 64'(mbus.o_data_addr), 64'(e_da));
      chk("status", {busy, halt}, {e_busy, m_act && m_halt});
      chk("count", 64'(cnt), 64'(m_cnt));
      chk("w_strobes",
          {w_sel_a, w_sel_b, w_wr_acc, w_op, wbus.o_rd_ram, wbus.o_wr_ram}, 0);
      if (mbus.o_rd_ram) rdq.push_back(mbus.o_data_addr);
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_halt(int max, output int n);
    n = 0;
    while (!halt && n < max) begin
      step(1);
      n++;
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; start = 1'b0; start_w = 1'b0;
    for (int i = 0; i < 2048; i++) prog[i] = 16'd0;
    step(1);
    chk_en = 1;
    step(1);
    rst = 1'b0;

    // idle with no start
    step(5);
    chk("idle_cnt", 64'(cnt), 0);
    chk("idle_busy", {busy, halt}, 0);

    // LDI 5; ADDI -2; STO 3; HLT
    prog[0] = {5'd3, 11'd5};
    prog[1] = {5'd5, 11'h7FE};
    prog[2] = {5'd1, 11'd3};
    prog[3] = 16'd0;
    pulse_start();
    chk("first_fetch", {busy, 11'(mbus.o_pc_addr)}, {1'b1, 11'd0});
    wait_halt(40, n);
    chk("halt_lat", 64'(n), 12);
    chk("cnt12", 64'(cnt), 12);
    chk("mem3", 64'(dmem[3]), 3);
    pulse_start();
    step(3);
    chk("halt_cnt", 64'(cnt), 12);
    chk("halt_pc", {halt, 11'(mbus.o_pc_addr)}, {1'b1, 11'd3});

    // LD 4; SUB 5; STO 6; HLT, start pulsed during EXEC of LD
    do_reset();
    prog[0] = {5'd2, 11'd4};
    prog[1] = {5'd6, 11'd5};
    prog[2] = {5'd1, 11'd6};
    prog[3] = 16'd0;
    pulse_start();
    step(2);
    pulse_start();
    wait_halt(40, n);
    chk("halt_lat2", 64'(n), 9);
    chk("mem6", 64'(dmem[6]), 7);
    chk("rd_cnt", 64'(rdq.size()), 2);
    if (rdq.size() == 2) begin
      chk("rd_addr0", 64'(rdq[0]), 4);
      chk("rd_addr1", 64'(rdq[1]), 5);
    end

    // reset mid-EXEC of ADDI, then restart
    do_reset();
    prog[0] = {5'd3, 11'd1};
    prog[1] = {5'd5, 11'd2};
    prog[2] = 16'd0;
    prog[3] = 16'd0;
    pulse_start();
    step(5);
    chk("addi_exec", 64'(wr_acc), 1);
    do_reset();
    chk("post_rst", {wr_acc, busy, halt, 11'(mbus.o_pc_addr)}, 0);
    chk("post_rst_cnt", 64'(cnt), 0);
    step(2);
    pulse_start();
    wait_halt(40, n);
    chk("restart_lat", 64'(n), 9);
    chk("restart_acc", 64'(acc), 3);

    // 4-bit PC wrap on a NOP-filled program
    start_w = 1'b1;
    step(1);
    start_w = 1'b0;
    for (int i = 0; i < 18; i++) begin
      chk("w_pc", {w_busy, 4'(wbus.o_pc_addr)}, {1'b1, 4'(i % 16)});
      step(3);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bip_control.md
# bip_control

Instruction sequencer for the BIP accumulator processor. It holds the program counter, fetches 16-bit instructions from program memory and decodes the 5-bit opcode. It drives the accumulator datapath controls (mux selects, accumulator write, add/sub) and the data-memory read/write strobes. It also exposes halt/busy status and an execution cycle counter for the debug unit.

## Interface
- NB_BITS, 16, instruction width
- NB_ADDR, 11, PC / operand / data-address width; instruction = {opcode[NB_BITS-1:NB_ADDR], operand[NB_ADDR-1:0]}
- NB_OPCODE, 5, opcode width (NB_BITS-NB_ADDR)
- NB_CNT, 32, cycle counter width
- i_clk  in  1  clock; all state changes on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  leave IDLE and begin execution at PC 0
- i_instr  in  NB_BITS  program memory read data, valid the cycle after o_pc_addr is presented
- o_pc_addr  out  NB_ADDR  program memory address
- o_data_addr  out  NB_ADDR  data memory address
- o_rd_ram  out  1  data memory read enable
- o_wr_ram  out  1  data memory write enable; write data is the accumulator
- o_sel_a  out  2  accumulator source: 00 memory, 01 sign-extended operand, 10 ALU result
- o_sel_b  out  1  ALU operand B: 0 memory, 1 sign-extended operand
- o_wr_acc  out  1  accumulator write enable
- o_op_code  out  1  ALU: 1 add, 0 subtract
- o_busy  out  1  high in FETCH/DECODE/EXEC
- o_halt  out  1  high in HALT
- o_cycle_count  out  NB_CNT  execution cycles since reset

## Operation
- FSM states: IDLE, FETCH, DECODE, EXEC, HALT. Reset state is IDLE.
- IDLE: waits for i_start, then goes to FETCH. i_start is ignored in every other state.
- FETCH: o_pc_addr = pc. Always goes to DECODE.
- DECODE: i_instr is latched into ir at the end of the cycle. o_data_addr = i_instr operand. o_rd_ram = 1 for LD, ADD, SUB. Always goes to EXEC.
- EXEC: decode ir and assert the strobes below for exactly one cycle. o_data_addr = ir operand.
  - HLT (00000): no strobes; go to HALT; pc unchanged.
  - STO (00001): o_wr_ram=1.
  - LD (00010): o_wr_acc=1, o_sel_a=00.
  - LDI (00011): o_wr_acc=1, o_sel_a=01.
  - ADD (00100): o_wr_acc=1, o_sel_a=10, o_sel_b=0, o_op_code=1.
  - ADDI (00101): o_wr_acc=1, o_sel_a=10, o_sel_b=1, o_op_code=1.
  - SUB (00110): o_wr_acc=1, o_sel_a=10, o_sel_b=0, o_op_code=0.
  - SUBI (00111): o_wr_acc=1, o_sel_a=10, o_sel_b=1, o_op_code=0.
  - Opcodes 01000–11111: NOP, no strobes.
  - Every non-HLT opcode: pc <= pc+1, then go to FETCH.
- HALT: o_halt=1 and all strobes 0. Left only by reset.
- PC wraps modulo 2^NB_ADDR: 2^NB_ADDR-1 goes to 0.
- o_cycle_count increments by 1 on every FETCH, DECODE and EXEC cycle. It is frozen in IDLE and HALT and saturates at all-ones.
- Outside the cycles listed above, o_sel_a, o_sel_b, o_op_code, o_wr_acc, o_rd_ram and o_wr_ram are 0.
- o_pc_addr always shows pc. o_data_addr shows ir operand outside DECODE.

## Timing
- Every instruction takes exactly 3 cycles (FETCH, DECODE, EXEC).
- Program memory and data memory both have 1-cycle synchronous read.
  - Data read in DECODE gives i_data_mem valid to the datapath in EXEC.
  - The accumulator updates on the edge that ends EXEC.
- STO writes the accumulator value present during EXEC.
- Reset values: pc 0, ir 0, o_pc_addr 0, o_data_addr 0, all strobes 0, o_busy 0, o_halt 0, o_cycle_count 0.
- Reset asserted in any state, including mid-instruction, takes priority over i_start. The next cycle is IDLE with reset values, and no strobe is asserted in the cycle after reset.
- First FETCH is the cycle after i_start is sampled high in IDLE.

## Test plan
- Reset/idle: hold i_rst 2 cycles, then idle 5 cycles with i_start=0. Expect all outputs 0, o_busy=0, counter stays 0.
- Program LDI 5; ADDI 0x7FE (-2); STO 3; HLT, with a datapath model.
  - EXEC strobes match the decode list.
  - mem[3]=3.
  - o_halt rises 12 cycles after the first FETCH; o_cycle_count=12 and stays frozen.
- Program LD 4 (mem[4]=10); SUB 5 (mem[5]=3); STO 6.
  - o_rd_ram high in DECODE with o_data_addr 4 and then 5.
  - mem[6]=7.
- Wrap: build with NB_ADDR=4 and fill memory with opcode 01000. After 16 instructions o_pc_addr returns to 0; no strobe is ever asserted.
- Reset mid-EXEC of ADDI: o_wr_acc is not asserted after reset; pc=0, state IDLE. i_start restarts at PC 0.
- i_start pulsed during EXEC and during HALT: no effect on pc, state or counter.
